ili9341_spi_ctrl: RTL and testbench

SPI master for an ILI9341 TFT panel that runs the power-up init sequence, then streams 16-bit RGB565 pixels from an upstream frame source into a 240×240 window. It sits between the pixel/frame logic and the display pins, is clocked by the divided clock `clk_out` from `freq_divider`, and supplies the pixel-rate strobe `data_clk` used upstream as a clock.

---
 rtl/ili9341_pkg.sv | 79 +++++++
 rtl/ili9341_spi_byte.sv | 83 ++++++++
 rtl/ili9341_spi_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ili9341_spi_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 SPI controller: command opcodes, controller
// states, the power-up init ROM and the fixed window-setup byte sequence.
package ili9341_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam logic [7:0] COLMOD_RGB565 = 8'h55;
    localparam logic [7:0] MADCTL_BGR_MX = 8'h48;

    localparam logic [3:0] INIT_LEN = 4'd7;
    localparam logic [3:0] WIN_LEN  = 4'd11;

    typedef enum logic [2:0] {
        RESET_WAIT,
        INIT,
        INIT_DELAY,
        IDLE,
        WINDOW,
        STREAM
    } state_t;

    typedef enum logic {
        DLY_NONE,
        DLY_120MS
    } delay_sel_t;

    typedef struct packed {
        logic       is_cmd;
        logic [7:0] data;
        delay_sel_t delay_sel;
    } rom_entry_t;

    function automatic rom_entry_t init_rom(input logic [3:0] idx);
        rom_entry_t e;
        e = '{is_cmd: 1'b0, data: 8'h00, delay_sel: DLY_NONE};
        case (idx)
            4'd0:    e = '{is_cmd: 1'b1, data: CMD_SWRESET,   delay_sel: DLY_120MS};
            4'd1:    e = '{is_cmd: 1'b1, data: CMD_SLPOUT,    delay_sel: DLY_120MS};
            4'd2:    e = '{is_cmd: 1'b1, data: CMD_COLMOD,    delay_sel: DLY_NONE};
            4'd3:    e = '{is_cmd: 1'b0, data: COLMOD_RGB565, delay_sel: DLY_NONE};
            4'd4:    e = '{is_cmd: 1'b1, data: CMD_MADCTL,    delay_sel: DLY_NONE};
            4'd5:    e = '{is_cmd: 1'b0, data: MADCTL_BGR_MX, delay_sel: DLY_NONE};
            4'd6:    e = '{is_cmd: 1'b1, data: CMD_DISPON,    delay_sel: DLY_NONE};
            default: ;
        endcase
        return e;
    endfunction

    // Window always starts at (0,0); only the end column/row vary with the panel size.
    function automatic logic [7:0] window_byte(input logic [3:0] idx,
                                               input logic [15:0] col_last,
                                               input logic [15:0] row_last);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = CMD_CASET;
            4'd3:    b = col_last[15:8];
            4'd4:    b = col_last[7:0];
            4'd5:    b = CMD_PASET;
            4'd8:    b = row_last[15:8];
            4'd9:    b = row_last[7:0];
            4'd10:   b = CMD_RAMWR;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic window_is_cmd(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == 4'd5) || (idx == 4'd10);
    endfunction

endpackage

// File: rtl/ili9341_spi_byte.sv
// Mode-0 SPI byte shifter: one byte in 16 clk_out cycles, MSB first, with done
// asserted in the last cycle so the next byte can start with no gap.
module ili9341_spi_byte (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       dc,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       mosi,
    output logic       dc_out
);

    logic       busy_q, busy_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       dc_q, dc_d;

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        dc_d    = dc_q;
        done    = busy_q && (cnt_q == 4'd15);

        // Even phases hold sck low with mosi settled, odd phases raise sck.
        if (start && (!busy_q || done)) begin
            busy_d  = 1'b1;
            cnt_d   = 4'd0;
            shift_d = {tx_byte[6:0], 1'b0};
            mosi_d  = tx_byte[7];
            sck_d   = 1'b0;
            dc_d    = dc;
        end else if (busy_q) begin
            if (done) begin
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
                shift_d = 8'h00;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 4'd1;
                if (!cnt_q[0]) begin
                    sck_d = 1'b1;
                end else begin
                    sck_d   = 1'b0;
                    mosi_d  = shift_q[7];
                    shift_d = {shift_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            dc_q    <= dc_d;
        end
    end

    assign busy   = busy_q;
    assign sck    = sck_q;
    assign mosi   = mosi_q;
    assign dc_out = dc_q;

endmodule

// File: rtl/ili9341_spi_ctrl.sv
// ILI9341 SPI controller: power-up init, window setup, then RGB565 pixel streaming
// paced by data_clk. Defining ILI9341_FAST_SIM_EN shortens all long delays to 64 cycles.
module ili9341_spi_ctrl
    import ili9341_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 240,
    parameter int CLK_HZ = 31_250_000
) (
    input  logic        clk_out,
    input  logic        rst,
    input  logic        frame_done,
    input  logic [15:0] input_data,
    output logic        spi_mosi,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic        spi_dc,
    output logic        data_clk
);

`ifdef ILI9341_FAST_SIM_EN
    localparam logic [31:0] RESET_CYCLES = 32'd64;
    localparam logic [31:0] SLEEP_CYCLES = 32'd64;
`else
    localparam logic [31:0] RESET_CYCLES = 32'(CLK_HZ / 1000 * 5);
    localparam logic [31:0] SLEEP_CYCLES = 32'(CLK_HZ / 1000 * 120);
`endif
    localparam logic [15:0] COL_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);

    state_t      state_q, state_d;
    logic [31:0] dly_q, dly_d;
    logic [4:0]  dclk_q, dclk_d;
    logic [3:0]  idx_q, idx_d;
    logic        pend_dly_q, pend_dly_d;
    logic        lo_pend_q, lo_pend_d;
    logic [7:0]  pix_lo_q, pix_lo_d;
    logic        cs_q, cs_d;
    logic        cs_prev_q, cs_prev_d;

    logic        start, busy, done, free, boundary, tx_dc;
    logic [7:0]  tx_byte;
    rom_entry_t  entry;

    ili9341_spi_byte u_byte (
        .clk_out (clk_out),
        .rst     (rst),
        .start   (start),
        .tx_byte (tx_byte),
        .dc      (tx_dc),
        .busy    (busy),
        .done    (done),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .dc_out  (spi_dc)
    );

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        dclk_d     = (state_q == RESET_WAIT) ? 5'd0 : dclk_q + 5'd1;
        idx_d      = idx_q;
        pend_dly_d = pend_dly_q;
        lo_pend_d  = lo_pend_q;
        pix_lo_d   = pix_lo_q;
        cs_d       = cs_q;
        cs_prev_d  = cs_q;
        start      = 1'b0;
        tx_byte    = 8'h00;
        tx_dc      = 1'b0;
        entry      = init_rom(idx_q);
        free       = !busy || done;
        boundary   = (dclk_q == 5'd31);

        case (state_q)
            RESET_WAIT: begin
                cs_d = 1'b1;
                if (dly_q == RESET_CYCLES - 32'd1) begin
                    dly_d   = 32'd0;
                    state_d = INIT;
                end else begin
                    dly_d = dly_q + 32'd1;
                end
            end
            INIT: begin
                cs_d = !(busy && !done);
                // Commands need cs to have been high for two cycles; parameters follow back-to-back.
                if (free) begin
                    if (pend_dly_q) begin
                        pend_dly_d = 1'b0;
                        state_d    = INIT_DELAY;
                    end else if (idx_q == INIT_LEN) begin
                        idx_d   = 4'd0;
                        state_d = IDLE;
                    end else if (!entry.is_cmd || (cs_q && cs_prev_q)) begin
                        start      = 1'b1;
                        tx_byte    = entry.data;
                        tx_dc      = !entry.is_cmd;
                        idx_d      = idx_q + 4'd1;
                        pend_dly_d = (entry.delay_sel == DLY_120MS);
                        cs_d       = 1'b0;
                    end
                end
            end
            INIT_DELAY: begin
                cs_d = 1'b1;
                if (dly_q == SLEEP_CYCLES - 32'd1) begin
                    dly_d   = 32'd0;
                    state_d = INIT;
                end else begin
                    dly_d = dly_q + 32'd1;
                end
            end
            IDLE: begin
                cs_d = 1'b1;
                if (boundary && !frame_done) begin
                    idx_d   = 4'd0;
                    state_d = WINDOW;
                end
            end
            WINDOW: begin
                cs_d = 1'b0;
                if (free) begin
                    if (idx_q == WIN_LEN) begin
                        idx_d   = 4'd0;
                        state_d = STREAM;
                    end else begin
                        start   = 1'b1;
                        tx_byte = window_byte(idx_q, COL_LAST, ROW_LAST);
                        tx_dc   = !window_is_cmd(idx_q);
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            STREAM: begin
                cs_d = 1'b0;
                // A pixel is two bytes exactly filling one data_clk slot, so the low byte ends on the boundary.
                if (lo_pend_q && done) begin
                    start     = 1'b1;
                    tx_byte   = pix_lo_q;
                    tx_dc     = 1'b1;
                    lo_pend_d = 1'b0;
                end else if (boundary && free) begin
                    if (frame_done) begin
                        cs_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        start     = 1'b1;
                        tx_byte   = input_data[15:8];
                        tx_dc     = 1'b1;
                        pix_lo_d  = input_data[7:0];
                        lo_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            state_q    <= RESET_WAIT;
            dly_q      <= 32'd0;
            dclk_q     <= 5'd0;
            idx_q      <= 4'd0;
            pend_dly_q <= 1'b0;
            lo_pend_q  <= 1'b0;
            pix_lo_q   <= 8'h00;
            cs_q       <= 1'b1;
            cs_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            dclk_q     <= dclk_d;
            idx_q      <= idx_d;
            pend_dly_q <= pend_dly_d;
            lo_pend_q  <= lo_pend_d;
            pix_lo_q   <= pix_lo_d;
            cs_q       <= cs_d;
            cs_prev_q  <= cs_prev_d;
        end
    end

    assign spi_cs   = cs_q;
    assign data_clk = dclk_q[4];

endmodule

// File: tb/tb_ili9341_spi_ctrl.sv
// Directed bench for ili9341_spi_ctrl: decodes the SPI bus into bytes and compares
// them against hand-written init, window and pixel tables plus a few timing corners.
module tb_ili9341_spi_ctrl;

    localparam int TB_CLK_HZ = 16000;
`ifdef ILI9341_FAST_SIM_EN
    localparam int RESET_CYC = 64;
    localparam int SLEEP_CYC = 64;
`else
    localparam int RESET_CYC = TB_CLK_HZ / 1000 * 5;
    localparam int SLEEP_CYC = TB_CLK_HZ / 1000 * 120;
`endif

    typedef struct {
        logic [7:0] data;
        logic       dc;
    } byte_vec_t;

    typedef struct {
        logic [15:0] pix;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } pix_vec_t;

    logic        clk_out = 1'b0;
    logic        rst;
    logic        frame_done;
    logic [15:0] input_data;
    logic        spi_mosi, spi_sck, spi_cs, spi_dc, data_clk;

    byte_vec_t init_tab[7];
    byte_vec_t win_tab[11];
    pix_vec_t  pix_tab[4];

    int errors = 0;
    int checks = 0;

    logic [7:0] mon_shift = 8'h00;
    int         mon_bits = 0;
    logic [8:0] mon_q[$];
    int         cs_run = 0;
    int         cs_runs[$];

    int base, base2, base3, first_rise, second_rise, k;
    logic prev_dclk;

    always #5 clk_out = ~clk_out;

    ili9341_spi_ctrl #(
        .WIDTH  (240),
        .HEIGHT (240),
        .CLK_HZ (TB_CLK_HZ)
    ) dut (
        .clk_out    (clk_out),
        .rst        (rst),
        .frame_done (frame_done),
        .input_data (input_data),
        .spi_mosi   (spi_mosi),
        .spi_sck    (spi_sck),
        .spi_cs     (spi_cs),
        .spi_dc     (spi_dc),
        .data_clk   (data_clk)
    );

    // SPI decoder: a partially shifted byte is discarded whenever cs rises.
    always @(posedge spi_sck or posedge spi_cs) begin
        if (spi_cs) begin
            mon_bits = 0;
        end else begin
            mon_shift = {mon_shift[6:0], spi_mosi};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_q.push_back({spi_dc, mon_shift});
                mon_bits = 0;
            end
        end
    end

    always @(negedge clk_out) begin
        if (spi_cs === 1'b1) begin
            cs_run++;
        end else if (cs_run != 0) begin
            cs_runs.push_back(cs_run);
            cs_run = 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic fd, input logic [15:0] d);
        @(negedge clk_out);
        rst        = r;
        frame_done = fd;
        input_data = d;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int cnt;
        cnt = 0;
        while (mon_q.size() < n && cnt < budget) begin
            @(negedge clk_out);
            cnt++;
        end
        if (mon_q.size() < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_timeout: got %0d bytes, expected %0d", mon_q.size(), n);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_cs"},   32'(spi_cs),   32'd1);
        check_output({tag, "_sck"},  32'(spi_sck),  32'd0);
        check_output({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
        check_output({tag, "_dc"},   32'(spi_dc),   32'd0);
        check_output({tag, "_dclk"}, 32'(data_clk), 32'd0);
    endtask

    task automatic check_byte(input string name, input int idx, input logic [7:0] exp_b, input logic exp_dc);
        logic [8:0] b;
        b = (idx < mon_q.size()) ? mon_q[idx] : 9'h1FF;
        check_output({name, "_byte"}, 32'(b[7:0]), 32'(exp_b));
        check_output({name, "_dc"},   32'(b[8]),   32'(exp_dc));
    endtask

    initial begin
        init_tab[0] = '{8'h01, 1'b0};
        init_tab[1] = '{8'h11, 1'b0};
        init_tab[2] = '{8'h3A, 1'b0};
        init_tab[3] = '{8'h55, 1'b1};
        init_tab[4] = '{8'h36, 1'b0};
        init_tab[5] = '{8'h48, 1'b1};
        init_tab[6] = '{8'h29, 1'b0};
        win_tab[0]  = '{8'h2A, 1'b0};
        win_tab[1]  = '{8'h00, 1'b1};
        win_tab[2]  = '{8'h00, 1'b1};
        win_tab[3]  = '{8'h00, 1'b1};
        win_tab[4]  = '{8'hEF, 1'b1};
        win_tab[5]  = '{8'h2B, 1'b0};
        win_tab[6]  = '{8'h00, 1'b1};
        win_tab[7]  = '{8'h00, 1'b1};
        win_tab[8]  = '{8'h00, 1'b1};
        win_tab[9]  = '{8'hEF, 1'b1};
        win_tab[10] = '{8'h2C, 1'b0};
        pix_tab[0]  = '{16'h1234, 8'h12, 8'h34};
        pix_tab[1]  = '{16'hABCD, 8'hAB, 8'hCD};
        pix_tab[2]  = '{16'h07E0, 8'h07, 8'hE0};
        pix_tab[3]  = '{16'h001F, 8'h00, 8'h1F};

        rst        = 1'b0;
        frame_done = 1'b1;
        input_data = 16'h0000;
        repeat (4) @(posedge clk_out);
        #1;
        check_reset("reset");

        // Power-up init with frame_done held high.
        apply_stimulus(1'b1, 1'b1, 16'h0000);
        wait_bytes(7, 20000);
        for (int i = 0; i < 7; i++)
            check_byte($sformatf("init%0d", i), i, init_tab[i].data, init_tab[i].dc);
        check_output("cs_run_count_init", 32'(cs_runs.size()), 32'd5);
        if (cs_runs.size() >= 5) begin
            check_output("reset_wait_min", 32'(cs_runs[0] >= RESET_CYC), 32'd1);
            check_output("cs_high_after_01", 32'(cs_runs[1]), 32'(SLEEP_CYC + 1));
            check_output("cs_high_after_11", 32'(cs_runs[2]), 32'(SLEEP_CYC + 1));
            check_output("cs_gap_before_36", 32'(cs_runs[3]), 32'd2);
            check_output("cs_gap_before_29", 32'(cs_runs[4]), 32'd2);
        end

        // Frame start with a constant red pixel.
        apply_stimulus(1'b1, 1'b0, 16'hF800);
        wait_bytes(7 + 11 + 6, 3000);
        for (int i = 0; i < 11; i++)
            check_byte($sformatf("win%0d", i), 7 + i, win_tab[i].data, win_tab[i].dc);
        for (int i = 0; i < 3; i++) begin
            check_byte($sformatf("red%0d_hi", i), 18 + 2 * i, 8'hF8, 1'b1);
            check_byte($sformatf("red%0d_lo", i), 19 + 2 * i, 8'h00, 1'b1);
        end

        // Upstream steps its pixel on each data_clk rise; the next slot must carry it.
        @(posedge data_clk);
        base = mon_q.size() + 1;
        input_data = pix_tab[0].pix;
        for (int i = 1; i < 4; i++) begin
            @(posedge data_clk);
            input_data = pix_tab[i].pix;
        end
        @(posedge data_clk);
        frame_done = 1'b1;
        repeat (80) @(negedge clk_out);
        for (int i = 0; i < 4; i++) begin
            check_byte($sformatf("step%0d_hi", i), base + 2 * i,     pix_tab[i].hi, 1'b1);
            check_byte($sformatf("step%0d_lo", i), base + 2 * i + 1, pix_tab[i].lo, 1'b1);
        end
        check_output("stop_byte_count", 32'(mon_q.size()), 32'(base + 8));
        check_output("stop_cs_high", 32'(spi_cs), 32'd1);
        check_output("stream_cs_no_gap", 32'(cs_runs.size()), 32'd6);

        first_rise  = -1;
        second_rise = -1;
        prev_dclk   = data_clk;
        for (k = 0; k < 200; k++) begin
            @(negedge clk_out);
            if (!prev_dclk && data_clk) begin
                if (first_rise < 0) first_rise = k;
                else if (second_rise < 0) second_rise = k;
            end
            prev_dclk = data_clk;
        end
        check_output("idle_dclk_period", 32'(second_rise - first_rise), 32'd32);

        // Restarting the frame re-sends the window before any pixel.
        base2 = mon_q.size();
        apply_stimulus(1'b1, 1'b0, pix_tab[3].pix);
        wait_bytes(base2 + 13, 3000);
        for (int i = 0; i < 11; i++)
            check_byte($sformatf("rewin%0d", i), base2 + i, win_tab[i].data, win_tab[i].dc);
        check_byte("restart_hi", base2 + 11, pix_tab[3].hi, 1'b1);
        check_byte("restart_lo", base2 + 12, pix_tab[3].lo, 1'b1);

        // Reset in the middle of a byte.
        k = 0;
        while (spi_sck !== 1'b1 && k < 200) begin
            @(negedge clk_out);
            k++;
        end
        check_output("sck_seen_before_reset", 32'(spi_sck), 32'd1);
        apply_stimulus(1'b0, 1'b1, pix_tab[3].pix);
        @(posedge clk_out);
        #1;
        check_reset("midbyte_reset");
        repeat (2) @(negedge clk_out);
        base3 = mon_q.size();
        apply_stimulus(1'b1, 1'b1, pix_tab[3].pix);
        wait_bytes(base3 + 7, 20000);
        for (int i = 0; i < 7; i++)
            check_byte($sformatf("reinit%0d", i), base3 + i, init_tab[i].data, init_tab[i].dc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
